// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle execute ALU.
//   master: execute-stage side, drives the request and operands and
//           receives in_ready, aluout, eq and out_valid.
//   slave : the ALU itself.
// Signals:
//   in_valid  request strobe          in_ready  ALU can accept this cycle
//   alusrc    1 = immop is operand 2  mext      M-extension op group
//   aluctrl   4-bit op select         aluop1    operand 1
//   immop     immediate operand       regop2    register operand 2
//   aluout    registered result       eq        registered branch flag
//   out_valid one-cycle result strobe
interface alu_mc_if #(
   parameter int D_WIDTH = 32
);
   logic               in_valid;
   logic               in_ready;
   logic               alusrc;
   logic               mext;
   logic [3:0]         aluctrl;
   logic [D_WIDTH-1:0] aluop1;
   logic [D_WIDTH-1:0] immop;
   logic [D_WIDTH-1:0] regop2;
   logic [D_WIDTH-1:0] aluout;
   logic               eq;
   logic               out_valid;

   modport master (
      output in_valid, alusrc, mext, aluctrl, aluop1, immop, regop2,
      input  in_ready, aluout, eq, out_valid
   );

   modport slave (
      input  in_valid, alusrc, mext, aluctrl, aluop1, immop, regop2,
      output in_ready, aluout, eq, out_valid
   );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute ALU. Base RV32I integer ops complete in one
// registered cycle; the M-extension uses an iterative shift-add multiplier
// and a restoring divider (D_WIDTH iterations each, latency D_WIDTH+1).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  alu_mc_if.slave (handshake, operands, result, eq, out_valid)
// Parameter:
//   D_WIDTH  datapath width, power of two, >= 8
// Build option:
//   ALU_MULH_EN  when defined, MULH/MULHSU/MULHU return the upper half of
//                the 2*D_WIDTH product; otherwise those codes take the
//                base path and return 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request, in_ready high
// MUL    | one add/shift multiplier step per cycle
// DIV    | one restoring-division quotient bit per cycle
// DONE   | result registered, out_valid high, can accept a new request
module alu_mc #(
   parameter int D_WIDTH = 32
) (
   input logic     clk,
   input logic     rst,
   alu_mc_if.slave bus
);
   localparam int W  = D_WIDTH;
   localparam int SW = $clog2(D_WIDTH);
   localparam int CW = SW + 1;
`ifdef ALU_MULH_EN
   localparam int AW = 2 * D_WIDTH;
`else
   localparam int AW = D_WIDTH;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          neg;        // product / quotient sign
   logic          rneg;       // remainder sign (follows dividend)
   logic          dz;         // divide by zero
   logic          sel_rem;    // DIV group: 1 = remainder
`ifdef ALU_MULH_EN
   logic          sel_lo;     // MUL group: 1 = low half
`endif
   logic [AW-1:0] acc;
   logic [W-1:0]  mc;
`ifndef ALU_MULH_EN
   logic [W-1:0]  mp;
`endif
   logic [W-1:0]  dvs;
   logic [W-1:0]  quo;
   logic [W-1:0]  rem;
   logic [W-1:0]  aluout_r;
   logic          eq_r;

   logic          accept;
   logic          go_mul;
   logic          go_div;
   logic [2:0]    code;
   logic [W-1:0]  op1;
   logic [W-1:0]  op2;
   logic [SW-1:0] shamt;

   assign bus.in_ready  = !rst && (state == S_IDLE || state == S_DONE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.aluout    = aluout_r;
   assign bus.eq        = eq_r;

   assign accept = bus.in_valid && bus.in_ready;
   assign code   = bus.aluctrl[2:0];
   assign op1    = bus.aluop1;
   assign op2    = bus.alusrc ? bus.immop : bus.regop2;
   assign shamt  = op2[SW-1:0];

   // Without the high-half option only MUL iterates; 001..011 fall to the
   // base path, which yields zero for any mext op.
`ifdef ALU_MULH_EN
   assign go_mul = bus.mext && !code[2];
`else
   assign go_mul = bus.mext && (code == 3'b000);
`endif
   assign go_div = bus.mext && code[2];

   logic [W-1:0] base_res;
   logic         base_eq;

   always_comb begin
      base_res = '0;
      if (!bus.mext) begin
         case (bus.aluctrl)
            4'b0000: base_res = op1 + op2;
            4'b1000: base_res = op1 - op2;
            4'b0001: base_res = op1 << shamt;
            4'b0010: base_res = {{(W-1){1'b0}}, ($signed(op1) < $signed(op2))};
            4'b0011: base_res = {{(W-1){1'b0}}, (op1 < op2)};
            4'b0100: base_res = op1 ^ op2;
            4'b0101: base_res = op1 >> shamt;
            4'b1101: base_res = $signed(op1) >>> shamt;
            4'b0110: base_res = op1 | op2;
            4'b0111: base_res = op1 & op2;
            4'b1111: base_res = op2;
            default: base_res = '0;
         endcase
      end
      base_eq = (!bus.mext && bus.aluctrl == 4'b0100) ? (base_res != '0) : base_res[0];
   end

   // Operand signedness and magnitudes at accept time.
   logic         sgn1;
   logic         sgn2;
   logic         neg1;
   logic         neg2;
   logic [W-1:0] mag1;
   logic [W-1:0] mag2;

   always_comb begin
      if (code[2]) begin
         sgn1 = !code[0];
         sgn2 = !code[0];
      end else begin
         sgn1 = (code == 3'b001) || (code == 3'b010);
         sgn2 = (code == 3'b001);
      end
      neg1 = sgn1 && op1[W-1];
      neg2 = sgn2 && op2[W-1];
      mag1 = neg1 ? -op1 : op1;
      mag2 = neg2 ? -op2 : op2;
   end

   // Iteration datapath.
   logic [CW-1:0] cnt_nxt;
   logic          last;
   logic [AW-1:0] acc_nxt;
   logic [AW-1:0] prod;
   logic [W-1:0]  mul_res;
   logic [W:0]    dshift;
   logic [W:0]    ddiff;
   logic [W-1:0]  rem_nxt;
   logic [W-1:0]  quo_nxt;
   logic [W-1:0]  q_fin;
   logic [W-1:0]  r_fin;
   logic [W-1:0]  div_res;
`ifdef ALU_MULH_EN
   logic [W:0]    msum;
`endif

   always_comb begin
      cnt_nxt = cnt - CW'(1);
      last    = (cnt_nxt == '0);
`ifdef ALU_MULH_EN
      // {hi, lo} accumulator: multiplier sits in lo and shifts out as the
      // product shifts in from the top.
      msum    = {1'b0, acc[AW-1:W]} + (acc[0] ? {1'b0, mc} : '0);
      acc_nxt = {msum, acc[W-1:1]};
      prod    = neg ? -acc_nxt : acc_nxt;
      mul_res = sel_lo ? prod[W-1:0] : prod[AW-1:W];
`else
      acc_nxt = acc + (mp[0] ? mc : '0);
      prod    = neg ? -acc_nxt : acc_nxt;
      mul_res = prod;
`endif
      dshift  = {rem, quo[W-1]};
      ddiff   = dshift - {1'b0, dvs};
      if (ddiff[W]) begin
         rem_nxt = dshift[W-1:0];
         quo_nxt = {quo[W-2:0], 1'b0};
      end else begin
         rem_nxt = ddiff[W-1:0];
         quo_nxt = {quo[W-2:0], 1'b1};
      end
      // A zero divisor leaves the magnitude remainder equal to the dividend,
      // so only the quotient needs forcing.
      q_fin   = dz ? '1 : (neg ? -quo_nxt : quo_nxt);
      r_fin   = rneg ? -rem_nxt : rem_nxt;
      div_res = sel_rem ? r_fin : q_fin;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         neg      <= 1'b0;
         rneg     <= 1'b0;
         dz       <= 1'b0;
         sel_rem  <= 1'b0;
`ifdef ALU_MULH_EN
         sel_lo   <= 1'b0;
`else
         mp       <= '0;
`endif
         acc      <= '0;
         mc       <= '0;
         dvs      <= '0;
         quo      <= '0;
         rem      <= '0;
         aluout_r <= '0;
         eq_r     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  cnt     <= CW'(W);
                  neg     <= neg1 ^ neg2;
                  sel_rem <= code[1];
`ifdef ALU_MULH_EN
                  sel_lo  <= (code[1:0] == 2'b00);
`endif
                  if (go_mul) begin
                     state <= S_MUL;
                     mc    <= mag1;
`ifdef ALU_MULH_EN
                     acc   <= {{W{1'b0}}, mag2};
`else
                     acc   <= '0;
                     mp    <= mag2;
`endif
                  end else if (go_div) begin
                     state <= S_DIV;
                     rneg  <= neg1;
                     dz    <= (op2 == '0);
                     dvs   <= mag2;
                     quo   <= mag1;
                     rem   <= '0;
                  end else begin
                     state    <= S_DONE;
                     aluout_r <= base_res;
                     eq_r     <= base_eq;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_MUL: begin
               cnt <= cnt_nxt;
               acc <= acc_nxt;
`ifndef ALU_MULH_EN
               mc  <= mc << 1;
               mp  <= mp >> 1;
`endif
               if (last) begin
                  state    <= S_DONE;
                  aluout_r <= mul_res;
                  eq_r     <= mul_res[0];
               end
            end
            S_DIV: begin
               cnt <= cnt_nxt;
               rem <= rem_nxt;
               quo <= quo_nxt;
               if (last) begin
                  state    <= S_DONE;
                  aluout_r <= div_res;
                  eq_r     <= div_res[0];
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
   localparam int W = 32;
`ifdef ALU_MULH_EN
   localparam bit MULH_EN = 1'b1;
`else
   localparam bit MULH_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_mc_if #(.D_WIDTH(W)) bus();
   alu_mc #(.D_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int unsigned acc_cyc;
      int unsigned due;
      bit          multi;
      logic [31:0] res;
      logic        eq;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   bit          chk_on = 0;
   logic [31:0] last_res = '0;
   logic        last_eq = 1'b0;
   bit          busy_c;
   bit          exp_v;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk32(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, act, exp);
      end
   endtask

   task automatic chk1(string n, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", n, cyc, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the architectural definition.
   function automatic logic [32:0] model(bit m, logic [3:0] c, logic [31:0] a, logic [31:0] b);
      logic [31:0]     r;
      int              sa;
      int              sb;
      longint          p;
      longint unsigned up;
      bit              ovf;
      logic            e;
      r   = '0;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (!m) begin
         case (c)
            4'd0:    r = a + b;
            4'd8:    r = a - b;
            4'd1:    r = a << b[4:0];
            4'd2:    r = (sa < sb) ? 32'd1 : 32'd0;
            4'd3:    r = (a < b) ? 32'd1 : 32'd0;
            4'd4:    r = a ^ b;
            4'd5:    r = a >> b[4:0];
            4'd13:   r = sa >>> b[4:0];
            4'd6:    r = a | b;
            4'd7:    r = a & b;
            4'd15:   r = b;
            default: r = '0;
         endcase
      end else begin
         case (c[2:0])
            3'd0: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); r = MULH_EN ? p[63:32] : '0; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); r = MULH_EN ? p[63:32] : '0; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; r = MULH_EN ? up[63:32] : '0; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
         endcase
      end
      e = (!m && c == 4'd4) ? (r != 0) : r[0];
      return {e, r};
   endfunction

   function automatic bit is_multi(bit m, logic [3:0] c);
      return m && (c[2] || c[2:0] == 3'd0 || MULH_EN);
   endfunction

   task automatic pin(string n, bit m, logic [3:0] c, logic [31:0] a, logic [31:0] b,
                      logic [31:0] er, logic ee);
      logic [32:0] mr;
      mr = model(m, c, a, b);
      chk32(n, mr[31:0], er);
      chk1(n, mr[32], ee);
   endtask

   // Called just after a rising edge; returns just after the accept edge.
   task automatic send(bit m, logic [3:0] c, logic [31:0] a, logic [31:0] imm,
                       logic [31:0] rg, bit src);
      logic [32:0] mr;
      exp_t        e;
      bit          ok;
      bus.in_valid = 1'b1;
      bus.mext     = m;
      bus.aluctrl  = c;
      bus.aluop1   = a;
      bus.immop    = imm;
      bus.regop2   = rg;
      bus.alusrc   = src;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout cyc=%0d got=no_accept exp=accept", cyc);
      end else begin
         mr        = model(m, c, a, src ? imm : rg);
         e.acc_cyc = cyc + 1;
         e.due     = cyc + 1 + (is_multi(m, c) ? W : 0);
         e.multi   = is_multi(m, c);
         e.res     = mr[31:0];
         e.eq      = mr[32];
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.aluop1   = $urandom();
      bus.immop    = $urandom();
      bus.regop2   = $urandom();
      bus.aluctrl  = 4'($urandom());
      bus.mext     = 1'($urandom());
      bus.alusrc   = 1'($urandom());
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
         busy_c = 0;
         foreach (q[i])
            if (q[i].multi && cyc >= q[i].acc_cyc && cyc < q[i].due) busy_c = 1;
         chk1("in_ready", bus.in_ready, !rst && !busy_c);
         exp_v = (q.size() > 0) && (q[0].due == cyc);
         chk1("out_valid", bus.out_valid, exp_v);
         if (exp_v) begin
            chk32("aluout", bus.aluout, q[0].res);
            chk1("eq", bus.eq, q[0].eq);
            last_res = q[0].res;
            last_eq  = q[0].eq;
            void'(q.pop_front());
         end else if (!rst) begin
            chk32("aluout_hold", bus.aluout, last_res);
            chk1("eq_hold", bus.eq, last_eq);
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.mext     = 1'b0;
      bus.aluctrl  = '0;
      bus.aluop1   = '0;
      bus.immop    = '0;
      bus.regop2   = '0;
      bus.alusrc   = 1'b0;

      pin("m_add", 0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0);
      pin("m_xor", 0, 4'd4, 32'hA5, 32'hA5, 32'd0, 1'b0);
      pin("m_sra", 0, 4'd13, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
      pin("m_mul", 1, 4'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b1);
      pin("m_mulhu", 1, 4'd3, 32'hFFFF_FFFF, 32'd3, MULH_EN ? 32'd2 : 32'd0, 1'b0);
      pin("m_div", 1, 4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
      pin("m_rem", 1, 4'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
      pin("m_divu0", 1, 4'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b1);
      pin("m_remu0", 1, 4'd7, 32'd7, 32'd0, 32'd7, 1'b1);
      pin("m_divovf", 1, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      pin("m_removf", 1, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);

      @(posedge clk);
      #1;
      chk_on = 1;
      idle(2);
      rst = 1'b0;
      idle(1);

      // base ops
      send(0, 4'd0, 32'd5, 32'd7, 32'd99, 1);
      idle(1);
      send(0, 4'd4, 32'hA5, 32'd0, 32'hA5, 0);
      send(0, 4'd13, 32'h8000_0000, 32'd0, 32'd4, 0);
      send(0, 4'd8, 32'd3, 32'd5, 32'd0, 1);
      send(0, 4'd1, 32'd1, 32'd33, 32'd0, 1);
      send(0, 4'd2, 32'hFFFF_FFFF, 32'd0, 32'd1, 0);
      send(0, 4'd3, 32'hFFFF_FFFF, 32'd0, 32'd1, 0);
      send(0, 4'd5, 32'h8000_0000, 32'd4, 32'd0, 1);
      send(0, 4'd6, 32'hF0F0_0000, 32'd0, 32'h0000_0F0F, 0);
      send(0, 4'd7, 32'hFF00_FF00, 32'h0FF0_0FF1, 32'd0, 1);
      send(0, 4'd15, 32'd1, 32'h1234_5679, 32'd0, 1);
      send(0, 4'd9, 32'd1, 32'd1, 32'd1, 1);
      send(0, 4'd4, 32'd6, 32'd2, 32'd0, 1);
      idle(2);

      // multiply group
      send(1, 4'd0, 32'hFFFF_FFFF, 32'd3, 32'd0, 1);
      send(1, 4'd3, 32'hFFFF_FFFF, 32'd0, 32'd3, 0);
      send(1, 4'd1, 32'hFFFF_FFFF, 32'd3, 32'd0, 1);
      send(1, 4'd2, 32'hFFFF_FFFF, 32'd3, 32'd0, 1);
      send(1, 4'd2, 32'd2, 32'hFFFF_FFFF, 32'd0, 1);
      send(1, 4'd1, 32'h8000_0000, 32'h8000_0000, 32'd0, 1);
      send(1, 4'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1);
      idle(2);

      // divide group
      send(1, 4'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 1);
      send(1, 4'd6, 32'hFFFF_FFF9, 32'd2, 32'd0, 1);
      send(1, 4'd5, 32'd7, 32'd0, 32'd0, 1);
      send(1, 4'd7, 32'd7, 32'd0, 32'd0, 1);
      send(1, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      send(1, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      send(1, 4'd4, 32'hFFFF_FFF9, 32'd0, 32'd0, 1);
      send(1, 4'd6, 32'hFFFF_FFF9, 32'd0, 32'd0, 1);
      send(1, 4'd5, 32'd100, 32'd7, 32'd0, 1);
      send(1, 4'd7, 32'd100, 32'd7, 32'd0, 1);
      send(1, 4'd6, 32'd7, 32'hFFFF_FFFE, 32'd0, 1);
      send(1, 4'd12, 32'd20, 32'hFFFF_FFFD, 32'd0, 1);
      idle(2);

      // reset in the middle of a divide
      send(1, 4'd4, 32'd1000, 32'd3, 32'd0, 1);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      last_res = '0;
      last_eq  = 1'b0;
      idle(3);
      send(0, 4'd0, 32'd1, 32'd1, 32'd0, 1);
      idle(2);

      // request held while the multiplier is busy
      send(1, 4'd0, 32'd7, 32'd6, 32'd0, 1);
      send(0, 4'd0, 32'd10, 32'd20, 32'd0, 1);
      send(0, 4'd8, 32'd10, 32'd20, 32'd0, 1);

      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain cyc=%0d got=%0d exp=0 pending", cyc, q.size());
      end
      idle(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
